mdu_hilo_ctrl: RTL and testbench

MDU_HILO_CTRL -- requirements
Module: mdu_hilo_ctrl

---
 rtl/mdu_hilo_ctrl_if.sv | 40 ++++
 rtl/mdu_hilo_ctrl.sv | 143 ++++++++++++++
 tb/tb_mdu_hilo_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_hilo_ctrl_if.sv
// Pipeline, MDU and HI/LO read-side signals of the HI/LO controller.
// slave is the controller's view; master is the view of the pipeline and MDU around it.
interface mdu_hilo_ctrl_if;
  logic        req_valid;
  logic [3:0]  req_op;
  logic [31:0] req_rs;
  logic [31:0] req_rt;
  logic        req_ready;
  logic        flush;

  logic        mdu_in_valid;
  logic        mdu_in_ready;
  logic [3:0]  mdu_op;
  logic [31:0] mdu_srcA;
  logic [31:0] mdu_srcB;
  logic        mdu_out_valid;
  logic        mdu_out_ready;
  logic [31:0] mdu_hi;
  logic [31:0] mdu_lo;

  logic [31:0] hi;
  logic [31:0] lo;
  logic        hilo_busy;

  modport slave (
    input  req_valid, req_op, req_rs, req_rt, flush,
    input  mdu_in_ready, mdu_out_valid, mdu_hi, mdu_lo,
    output req_ready,
    output mdu_in_valid, mdu_op, mdu_srcA, mdu_srcB, mdu_out_ready,
    output hi, lo, hilo_busy
  );

  modport master (
    output req_valid, req_op, req_rs, req_rt, flush,
    output mdu_in_ready, mdu_out_valid, mdu_hi, mdu_lo,
    input  req_ready,
    input  mdu_in_valid, mdu_op, mdu_srcA, mdu_srcB, mdu_out_ready,
    input  hi, lo, hilo_busy
  );
endinterface

// File: rtl/mdu_hilo_ctrl.sv
// HI/LO owner: runs MULT/DIV through the MDU handshake, MTHI/MTLO write directly, flush cancels or drains.
// Define HILO_FWD_EN to forward the value being written onto hi/lo and release hilo_busy in the result cycle.
`ifndef MULT
`define MULT  4'd1
`endif
`ifndef MULTU
`define MULTU 4'd2
`endif
`ifndef DIV
`define DIV   4'd3
`endif
`ifndef DIVU
`define DIVU  4'd4
`endif
`ifndef MTHI
`define MTHI  4'd5
`endif
`ifndef MTLO
`define MTLO  4'd6
`endif

module mdu_hilo_ctrl (
  input  logic           clk,
  input  logic           reset,
  mdu_hilo_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_e;

  state_e      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] srca_q, srca_d;
  logic [31:0] srcb_q, srcb_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic req_ready;
  logic in_valid;
  logic out_ready;
  logic busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= 4'd0;
      srca_q  <= 32'd0;
      srcb_q  <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      srca_q  <= srca_d;
      srcb_q  <= srcb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    srca_d    = srca_q;
    srcb_d    = srcb_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    req_ready = (state_q == IDLE) & ~bus.flush;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    busy      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid & req_ready) begin
          case (bus.req_op)
            `MULT, `MULTU, `DIV, `DIVU: begin
              op_d    = bus.req_op;
              srca_d  = bus.req_rs;
              srcb_d  = bus.req_rt;
              state_d = ISSUE;
            end
            `MTHI:   hi_d = bus.req_rs;
            `MTLO:   lo_d = bus.req_rs;
            default: ;
          endcase
        end
      end

      ISSUE: begin
        in_valid = 1'b1;
        busy     = 1'b1;
        // Once the MDU has taken the op, a flush can only discard its result.
        if (bus.mdu_in_ready) begin
          state_d = bus.flush ? DRAIN : WAIT;
        end else if (bus.flush) begin
          state_d = IDLE;
        end
      end

      WAIT: begin
        out_ready = 1'b1;
`ifdef HILO_FWD_EN
        busy      = ~(bus.mdu_out_valid & ~bus.flush);
`else
        busy      = 1'b1;
`endif
        if (bus.flush) begin
          state_d = bus.mdu_out_valid ? IDLE : DRAIN;
        end else if (bus.mdu_out_valid) begin
          hi_d    = bus.mdu_hi;
          lo_d    = bus.mdu_lo;
          state_d = IDLE;
        end
      end

      DRAIN: begin
        out_ready = 1'b1;
        if (bus.mdu_out_valid) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready     = req_ready;
  assign bus.mdu_in_valid  = in_valid;
  assign bus.mdu_out_ready = out_ready;
  assign bus.mdu_op        = op_q;
  assign bus.mdu_srcA      = srca_q;
  assign bus.mdu_srcB      = srcb_q;
  assign bus.hilo_busy     = busy;

`ifdef HILO_FWD_EN
  assign bus.hi = hi_d;
  assign bus.lo = lo_d;
`else
  assign bus.hi = hi_q;
  assign bus.lo = lo_q;
`endif

endmodule

// File: tb/tb_mdu_hilo_ctrl.sv
// Randomized bench for mdu_hilo_ctrl: an emulated MDU with variable latency plus a transaction-level
// model of the architectural HI/LO state and the pending multiply/divide.
`ifndef MULT
`define MULT  4'd1
`endif
`ifndef MULTU
`define MULTU 4'd2
`endif
`ifndef DIV
`define DIV   4'd3
`endif
`ifndef DIVU
`define DIVU  4'd4
`endif
`ifndef MTHI
`define MTHI  4'd5
`endif
`ifndef MTLO
`define MTLO  4'd6
`endif

module tb_mdu_hilo_ctrl;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mdu_hilo_ctrl_if bus ();

  mdu_hilo_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Architectural view: HI/LO, and the op the controller owns (accepted, handed to MDU, cancelled).
  logic [31:0] m_hi, m_lo;
  bit          m_owns, m_handed, m_dropped;
  logic [3:0]  p_op;
  logic [31:0] p_a, p_b;

  // Emulated MDU: result appears e_cnt cycles after the input handshake.
  bit          e_busy;
  int          e_cnt;
  logic [31:0] e_hi, e_lo;
  int          next_lat;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] h, output logic [31:0] l);
    longint      sa, sb, p;
    logic [63:0] u;
    h = 32'd0;
    l = 32'd0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      `MULT: begin
        p = sa * sb;
        h = p[63:32];
        l = p[31:0];
      end
      `MULTU: begin
        u = {32'd0, a} * {32'd0, b};
        h = u[63:32];
        l = u[31:0];
      end
      `DIV: if (b != 0) begin
        p = sa / sb;
        l = p[31:0];
        p = sa % sb;
        h = p[31:0];
      end
      `DIVU: if (b != 0) begin
        l = a / b;
        h = a % b;
      end
      default: ;
    endcase
  endfunction

  task automatic step(input bit rv, input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                      input bit fl, input bit inr, input bit rst);
    logic [31:0] ehi, elo, x_hi, x_lo;
    bit          e_ready, e_ovalid, commit, x_busy;
    @(negedge clk);
    e_ready  = inr && !e_busy;
    e_ovalid = e_busy && (e_cnt == 0);
    bus.req_valid     = rv;
    bus.req_op        = op;
    bus.req_rs        = rs;
    bus.req_rt        = rt;
    bus.flush         = fl;
    bus.mdu_in_ready  = e_ready;
    bus.mdu_out_valid = e_ovalid;
    bus.mdu_hi        = e_hi;
    bus.mdu_lo        = e_lo;
    reset             = rst;
    #1;
    calc(p_op, p_a, p_b, ehi, elo);
    commit = m_owns && m_handed && !m_dropped && e_ovalid && !fl;
    x_hi   = m_hi;
    x_lo   = m_lo;
    x_busy = m_owns && !m_dropped;
`ifdef HILO_FWD_EN
    if (commit) begin
      x_hi   = ehi;
      x_lo   = elo;
      x_busy = 1'b0;
    end else if (!m_owns && rv && !fl && op == `MTHI) begin
      x_hi = rs;
    end else if (!m_owns && rv && !fl && op == `MTLO) begin
      x_lo = rs;
    end
`endif
    chk("req_ready", bus.req_ready, !m_owns && !fl);
    chk("mdu_in_valid", bus.mdu_in_valid, m_owns && !m_handed);
    chk("mdu_out_ready", bus.mdu_out_ready, m_owns && m_handed);
    chk("hilo_busy", bus.hilo_busy, x_busy);
    chk("hi", bus.hi, x_hi);
    chk("lo", bus.lo, x_lo);
    if (m_owns && !m_handed) begin
      chk("mdu_op", bus.mdu_op, p_op);
      chk("mdu_srcA", bus.mdu_srcA, p_a);
      chk("mdu_srcB", bus.mdu_srcB, p_b);
    end

    if (rst) begin
      m_hi = 0; m_lo = 0;
      m_owns = 0; m_handed = 0; m_dropped = 0;
      p_op = 0; p_a = 0; p_b = 0;
      e_busy = 0; e_cnt = 0;
    end else begin
      if (e_busy) begin
        if (e_ovalid && bus.mdu_out_ready) e_busy = 0;
        else if (e_cnt > 0) e_cnt--;
      end else if (e_ready && bus.mdu_in_valid) begin
        e_busy = 1;
        e_cnt  = next_lat;
        calc(bus.mdu_op, bus.mdu_srcA, bus.mdu_srcB, e_hi, e_lo);
      end

      if (!m_owns) begin
        if (rv && !fl) begin
          case (op)
            `MULT, `MULTU, `DIV, `DIVU: begin
              m_owns = 1; p_op = op; p_a = rs; p_b = rt;
            end
            `MTHI:   m_hi = rs;
            `MTLO:   m_lo = rs;
            default: ;
          endcase
        end
      end else if (!m_handed) begin
        if (e_ready) begin
          m_handed  = 1;
          m_dropped = fl;
        end else if (fl) begin
          m_owns = 0;
        end
      end else if (e_ovalid) begin
        if (commit) begin
          m_hi = ehi;
          m_lo = elo;
        end
        m_owns = 0; m_handed = 0; m_dropped = 0;
      end else if (fl) begin
        m_dropped = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic nop(input bit inr);
    step(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, inr, 1'b0);
  endtask

  logic [3:0] ops [8];

  initial begin
    ops = '{`MULT, `MULTU, `DIV, `DIVU, `MTHI, `MTLO, 4'd0, 4'd9};
    m_hi = 0; m_lo = 0; m_owns = 0; m_handed = 0; m_dropped = 0;
    p_op = 0; p_a = 0; p_b = 0;
    e_busy = 0; e_cnt = 0; e_hi = 0; e_lo = 0; next_lat = 0;

    bus.req_valid = 0; bus.req_op = 0; bus.req_rs = 0; bus.req_rt = 0; bus.flush = 0;
    bus.mdu_in_ready = 0; bus.mdu_out_valid = 0; bus.mdu_hi = 0; bus.mdu_lo = 0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_in_valid", bus.mdu_in_valid, 0);
    chk("rst_out_ready", bus.mdu_out_ready, 0);
    chk("rst_busy", bus.hilo_busy, 0);

    // MTHI writes HI only, no MDU traffic
    step(1, `MTHI, 32'h12345678, 32'd0, 0, 1, 0);
    chk("mthi_hi", bus.hi, 32'h12345678);
    chk("mthi_lo", bus.lo, 32'd0);
    chk("mthi_no_issue", bus.mdu_in_valid, 0);

    // Flush in IDLE suppresses MTLO
    step(1, `MTLO, 32'hDEADBEEF, 32'd0, 1, 1, 0);
    chk("flush_idle_lo", bus.lo, 32'd0);

    // Best-case MULT
    next_lat = 0;
    step(1, `MULT, 32'hFFFFFFFF, 32'h2, 0, 1, 0);
    chk("mul_busy_c1", bus.hilo_busy, 1);
    nop(1);
    nop(1);
    chk("mul_hi", bus.hi, 32'hFFFFFFFF);
    chk("mul_lo", bus.lo, 32'hFFFFFFFE);
    chk("mul_ready_c3", bus.req_ready, 1);

    // DIVU with latency
    next_lat = 2;
    step(1, `DIVU, 32'd100, 32'd7, 0, 1, 0);
    repeat (4) nop(1);
    chk("divu_lo", bus.lo, 32'd14);
    chk("divu_hi", bus.hi, 32'd2);

    // DIV flushed in WAIT, drained, then MULT 3*4
    step(1, `MTHI, 32'hAAAA0001, 32'd0, 0, 1, 0);
    step(1, `MTLO, 32'h55550002, 32'd0, 0, 1, 0);
    next_lat = 6;
    step(1, `DIV, 32'hFFFFFFF9, 32'd2, 0, 1, 0);
    nop(1);
    nop(1);
    nop(1);
    step(0, 4'd0, 32'd0, 32'd0, 1, 1, 0);
    chk("drain_out_ready", bus.mdu_out_ready, 1);
    chk("drain_not_busy", bus.hilo_busy, 0);
    repeat (4) nop(1);
    chk("drain_hi", bus.hi, 32'hAAAA0001);
    chk("drain_lo", bus.lo, 32'h55550002);
    next_lat = 1;
    step(1, `MULT, 32'd3, 32'd4, 0, 1, 0);
    repeat (3) nop(1);
    chk("mul34_lo", bus.lo, 32'd12);
    chk("mul34_hi", bus.hi, 32'd0);

    // Flush while MDU never accepts
    step(1, `MULT, 32'd5, 32'd6, 0, 1, 0);
    nop(0);
    nop(0);
    step(0, 4'd0, 32'd0, 32'd0, 1, 0, 0);
    chk("iflush_lo", bus.lo, 32'd12);
    chk("iflush_idle", bus.mdu_in_valid, 0);

    // Reset during WAIT of DIVU
    next_lat = 5;
    step(1, `DIVU, 32'd100, 32'd7, 0, 1, 0);
    nop(1);
    nop(1);
    step(0, 4'd0, 32'd0, 32'd0, 0, 1, 1);
    chk("wrst_hi", bus.hi, 32'd0);
    chk("wrst_lo", bus.lo, 32'd0);
    chk("wrst_ready", bus.req_ready, 1);
    chk("wrst_out_ready", bus.mdu_out_ready, 0);

    for (int i = 0; i < 3000; i++) begin
      logic [3:0]  op;
      logic [31:0] rs, rt;
      op = ops[$urandom_range(0, 7)];
      case ($urandom_range(0, 3))
        0:       rs = 32'hFFFFFFFF;
        1:       rs = 32'h80000000;
        default: rs = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0:       rt = 32'hFFFFFFFF;
        1:       rt = $urandom_range(1, 9);
        default: rt = $urandom;
      endcase
      if (rt == 32'd0) rt = 32'd1;
      next_lat = $urandom_range(0, 4);
      step($urandom_range(0, 3) != 0, op, rs, rt, $urandom_range(0, 9) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 199) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
